// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared encodings for the execute stage: ALU/branch codes, operand selects, CSR map
// Contents: alu_op_e (funct3 ALU ops), branch funct3 codes, OP_BRANCH opcode,
//           amux1/amux2 select encodings, CSR addresses, mstatus reset value.
package execute_stage_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] AMUX1_SRC1 = 2'b00;
    localparam logic [1:0] AMUX1_PC   = 2'b01;

    localparam logic [1:0] AMUX2_SRC2 = 2'b00;
    localparam logic [1:0] AMUX2_IMM  = 2'b01;
    localparam logic [1:0] AMUX2_FOUR = 2'b10;
    localparam logic [1:0] AMUX2_ZERO = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode-to-execute bundle: operands, op controls, CSR access and results
// master: decode side, drives operands/controls and reads results.
// slave : execute stage, reads operands/controls and drives aluout, ben, csr_rdata.
interface execute_stage_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [9:0]        func_eu;
    logic [1:0]        amux1;
    logic [1:0]        amux2;
    logic [2:0]        func3;
    logic [6:0]        opcode;
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_wen;
    logic [XLEN-1:0]   aluout;
    logic              ben;
    logic [XLEN-1:0]   csr_rdata;

    modport master (
        output src1, src2, imm, pc, func_eu, amux1, amux2, func3, opcode, csr_addr, csr_wen,
        input  aluout, ben, csr_rdata
    );

    modport slave (
        input  src1, src2, imm, pc, func_eu, amux1, amux2, func3, opcode, csr_addr, csr_wen,
        output aluout, ben, csr_rdata
    );
endinterface

// File: rtl/execute_stage_csr_file.sv
// rtl/execute_stage_csr_file.sv - machine CSR file: mstatus, mtvec, mepc, mcause
// Ports: clk, rst (sync active-high), addr/wen/wdata write port, rdata combinational read.
// Reads return the pre-write value during a write cycle; unmapped addresses read 0
// and swallow writes.
module csr_file
    import execute_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CSR_AW-1:0] addr,
    input  logic              wen,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q,   mtvec_d;
    logic [XLEN-1:0] mepc_q,    mepc_d;
    logic [XLEN-1:0] mcause_q,  mcause_d;

    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (wen) begin
            case (addr)
                CSR_AW'(CSR_MSTATUS): mstatus_d = wdata;
                CSR_AW'(CSR_MTVEC):   mtvec_d   = wdata;
                CSR_AW'(CSR_MEPC):    mepc_d    = wdata;
                CSR_AW'(CSR_MCAUSE):  mcause_d  = wdata;
                default: ;
            endcase
        end
    end

    // Reset is checked first so it overrides a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= XLEN'(MSTATUS_RST);
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CSR_AW'(CSR_MSTATUS): rdata = mstatus_q;
            CSR_AW'(CSR_MTVEC):   rdata = mtvec_q;
            CSR_AW'(CSR_MEPC):    rdata = mepc_q;
            CSR_AW'(CSR_MCAUSE):  rdata = mcause_q;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: operand muxes, ALU, branch compare, CSR file
// Ports: clk, rst (sync active-high, CSRs only), ex (execute_stage_if.slave).
// aluout and ben are purely combinational; aluout doubles as jump target and CSR write data.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    execute_stage_if.slave ex
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic            alt;
    alu_op_e         alu_op;

    // Only funct7 bit 5 (func_eu[8]) carries meaning; the rest are don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{ex.func_eu[9], ex.func_eu[7:3]};

    assign alu_op = alu_op_e'(ex.func_eu[2:0]);
    assign alt    = ex.func_eu[8];
    assign shamt  = op_b[4:0];

    always_comb begin
        op_a = '0;
        case (ex.amux1)
            AMUX1_SRC1: op_a = ex.src1;
            AMUX1_PC:   op_a = ex.pc;
            default:    op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (ex.amux2)
            AMUX2_SRC2: op_b = ex.src2;
            AMUX2_IMM:  op_b = ex.imm;
            AMUX2_FOUR: op_b = XLEN'(4);
            AMUX2_ZERO: op_b = '0;
            default:    op_b = '0;
        endcase
    end

    always_comb begin
        ex.aluout = '0;
        case (alu_op)
            ALU_ADD:  ex.aluout = alt ? (op_a - op_b) : (op_a + op_b);
            ALU_SLL:  ex.aluout = op_a << shamt;
            ALU_SLT:  ex.aluout = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: ex.aluout = XLEN'(op_a < op_b);
            ALU_XOR:  ex.aluout = op_a ^ op_b;
            ALU_SRL:  ex.aluout = alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
            ALU_OR:   ex.aluout = op_a | op_b;
            ALU_AND:  ex.aluout = op_a & op_b;
            default:  ex.aluout = '0;
        endcase
    end

    // Branch compare works on the raw register operands, independent of the ALU muxes.
    always_comb begin
        ex.ben = 1'b0;
        if (ex.opcode == OP_BRANCH) begin
            case (ex.func3)
                BR_BEQ:  ex.ben = (ex.src1 == ex.src2);
                BR_BNE:  ex.ben = (ex.src1 != ex.src2);
                BR_BLT:  ex.ben = ($signed(ex.src1) <  $signed(ex.src2));
                BR_BGE:  ex.ben = ($signed(ex.src1) >= $signed(ex.src2));
                BR_BLTU: ex.ben = (ex.src1 <  ex.src2);
                BR_BGEU: ex.ben = (ex.src1 >= ex.src2);
                default: ex.ben = 1'b0;
            endcase
        end
    end

    csr_file #(
        .XLEN   (XLEN),
        .CSR_AW (CSR_AW)
    ) u_csr_file (
        .clk   (clk),
        .rst   (rst),
        .addr  (ex.csr_addr),
        .wen   (ex.csr_wen),
        .wdata (ex.aluout),
        .rdata (ex.csr_rdata)
    );

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage with directed vectors
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_if #(.XLEN(32), .CSR_AW(12)) ex_if ();

    execute_stage #(.XLEN(32), .CSR_AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex_if)
    );

    localparam int SEL_ALU = 0;
    localparam int SEL_BEN = 1;
    localparam int SEL_CSR = 2;

    int errors = 0;
    int checks = 0;

    int          q_sel[$];
    logic [31:0] q_exp[$];
    string       q_name[$];

    task automatic expect_out(input int sel, input logic [31:0] v, input string n);
        q_sel.push_back(sel);
        q_exp.push_back(v);
        q_name.push_back(n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [1:0] a1, input logic [1:0] a2, input logic [9:0] f,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] im, input logic [31:0] p);
        ex_if.amux1   = a1;
        ex_if.amux2   = a2;
        ex_if.func_eu = f;
        ex_if.src1    = s1;
        ex_if.src2    = s2;
        ex_if.imm     = im;
        ex_if.pc      = p;
    endtask

    task automatic set_br(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] s1, input logic [31:0] s2);
        ex_if.opcode = op;
        ex_if.func3  = f3;
        ex_if.src1   = s1;
        ex_if.src2   = s2;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic w, input logic [31:0] wdata);
        ex_if.csr_addr = a;
        ex_if.csr_wen  = w;
        set_alu(2'b00, 2'b00, 10'd0, wdata, 32'd0, 32'd0, 32'd0);
    endtask

    // Monitor: outputs are combinational, so whatever is queued is compared at the falling edge.
    int          m_sel;
    logic [31:0] m_exp;
    logic [31:0] m_act;
    string       m_name;
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            m_sel  = q_sel.pop_front();
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            case (m_sel)
                SEL_ALU: m_act = ex_if.aluout;
                SEL_BEN: m_act = {31'd0, ex_if.ben};
                default: m_act = ex_if.csr_rdata;
            endcase
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ex_if.csr_addr = 12'h000;
        ex_if.csr_wen  = 1'b0;
        ex_if.opcode   = 7'd0;
        ex_if.func3    = 3'd0;
        set_alu(2'b00, 2'b00, 10'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Reset values
        ex_if.csr_addr = 12'h300; expect_out(SEL_CSR, 32'h0000_1800, "rst_mstatus"); step();
        ex_if.csr_addr = 12'h305; expect_out(SEL_CSR, 32'h0,         "rst_mtvec");   step();
        ex_if.csr_addr = 12'h341; expect_out(SEL_CSR, 32'h0,         "rst_mepc");    step();
        ex_if.csr_addr = 12'h342; expect_out(SEL_CSR, 32'h0,         "rst_mcause");  step();

        // ALU vectors
        set_alu(2'b00, 2'b00, 10'b0100000_000, 32'd5, 32'd7, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'hFFFF_FFFE, "sub"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_000, 32'd5, 32'd7, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'd12, "add"); step();
        set_alu(2'b00, 2'b00, 10'b1011111_000, 32'd5, 32'd7, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'd12, "add_f7_ignored"); step();
        set_alu(2'b00, 2'b01, 10'b0100000_101, 32'h8000_0000, 32'd0, 32'h24, 32'd0);
        expect_out(SEL_ALU, 32'hF800_0000, "sra"); step();
        set_alu(2'b00, 2'b01, 10'b0000000_101, 32'h8000_0000, 32'd0, 32'h24, 32'd0);
        expect_out(SEL_ALU, 32'h0800_0000, "srl"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_001, 32'd1, 32'h23, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'd8, "sll_shamt5"); step();
        set_alu(2'b01, 2'b01, 10'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h8000_0010);
        expect_out(SEL_ALU, 32'h8000_0000, "pc_plus_imm"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'd1, "slt"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'd0, "sltu"); step();
        set_alu(2'b00, 2'b00, 10'b0100000_100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'h0FF0_0FF0, "xor_alt_ignored"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'hFFF0_FFF0, "or"); step();
        set_alu(2'b00, 2'b00, 10'b0000000_111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0);
        expect_out(SEL_ALU, 32'hF000_F000, "and"); step();
        set_alu(2'b10, 2'b10, 10'd0, 32'h55, 32'h66, 32'd0, 32'h100);
        expect_out(SEL_ALU, 32'd4, "zero_plus_four"); step();
        set_alu(2'b00, 2'b11, 10'd0, 32'd5, 32'h66, 32'h77, 32'd0);
        expect_out(SEL_ALU, 32'd5, "src1_plus_zero"); step();

        // Branch vectors
        set_br(7'b1100011, 3'b100, 32'hFFFF_FFFF, 32'd1); expect_out(SEL_BEN, 32'd1, "blt");  step();
        set_br(7'b1100011, 3'b110, 32'hFFFF_FFFF, 32'd1); expect_out(SEL_BEN, 32'd0, "bltu"); step();
        set_br(7'b0110011, 3'b100, 32'hFFFF_FFFF, 32'd1); expect_out(SEL_BEN, 32'd0, "not_branch"); step();
        set_br(7'b1100011, 3'b101, 32'hFFFF_FFFF, 32'd1); expect_out(SEL_BEN, 32'd0, "bge");  step();
        set_br(7'b1100011, 3'b111, 32'hFFFF_FFFF, 32'd1); expect_out(SEL_BEN, 32'd1, "bgeu"); step();
        set_br(7'b1100011, 3'b010, 32'd3, 32'd3);         expect_out(SEL_BEN, 32'd0, "f3_010"); step();
        set_br(7'b1100011, 3'b001, 32'd3, 32'd3);         expect_out(SEL_BEN, 32'd0, "bne_eq"); step();
        set_alu(2'b01, 2'b10, 10'd0, 32'd9, 32'd9, 32'd0, 32'h40);
        set_br(7'b1100011, 3'b000, 32'd9, 32'd9);         expect_out(SEL_BEN, 32'd1, "beq_src_only"); step();
        set_br(7'b0000000, 3'b000, 32'd0, 32'd0);

        // CSR write / read-back
        csr_op(12'h305, 1'b1, 32'h8000_0100);
        expect_out(SEL_CSR, 32'h0, "mtvec_old_during_write"); step();
        csr_op(12'h305, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'h8000_0100, "mtvec_new"); step();
        csr_op(12'h7C0, 1'b1, 32'hDEAD_BEEF); step();
        csr_op(12'h7C0, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'h0, "unmapped_reads_zero"); step();
        csr_op(12'h342, 1'b1, 32'h42); step();
        csr_op(12'h342, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'h42, "mcause_new"); step();
        csr_op(12'h300, 1'b1, 32'hFFFF_0000); step();
        csr_op(12'h300, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'hFFFF_0000, "mstatus_new"); step();
        csr_op(12'h341, 1'b1, 32'h5555); step();
        csr_op(12'h341, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'h5555, "mepc_new"); step();

        // Reset beats a simultaneous write; ALU unaffected by reset
        rst = 1'b1;
        csr_op(12'h341, 1'b1, 32'h1234);
        expect_out(SEL_ALU, 32'h1234, "alu_during_rst");
        expect_out(SEL_CSR, 32'h5555, "mepc_old_during_rst"); step();
        rst = 1'b0;
        csr_op(12'h341, 1'b0, 32'h0);
        expect_out(SEL_CSR, 32'h0, "mepc_rst_wins"); step();
        ex_if.csr_addr = 12'h300; expect_out(SEL_CSR, 32'h0000_1800, "mstatus_rst_again"); step();
        ex_if.csr_addr = 12'h342; expect_out(SEL_CSR, 32'h0,         "mcause_rst_again");  step();

        // Drain, bounded
        for (int i = 0; i < 5; i++) begin
            if (q_sel.size() == 0) break;
            step();
        end
        checks++;
        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q_sel.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter CSR_AW, default 12: CSR address width.
REQ-003 clk  input  1  single clock; CSR writes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 src1  input  XLEN  rs1 operand.
REQ-006 src2  input  XLEN  rs2 operand.
REQ-007 imm  input  XLEN  decoded immediate.
REQ-008 pc  input  XLEN  current instruction address.
REQ-009 func_eu  input  10  ALU op, {funct7, funct3}.
REQ-010 amux1  input  2  ALU operand-A select.
REQ-011 amux2  input  2  ALU operand-B select.
REQ-012 func3  input  3  branch condition.
REQ-013 opcode  input  7  instruction opcode.
REQ-014 csr_addr  input  CSR_AW  CSR index.
REQ-015 csr_wen  input  1  CSR write enable.
REQ-016 aluout  output  XLEN  ALU result; also branch/jump target and CSR write data.
REQ-017 ben  output  1  branch taken.
REQ-018 csr_rdata  output  XLEN  CSR read data.

Function
REQ-019 Operand A SHALL be: amux1 00 = src1, 01 = pc, 10/11 = 0.
REQ-020 Operand B SHALL be: amux2 00 = src2, 01 = imm, 10 = 32'd4, 11 = 0.
REQ-021 ALU op SHALL be selected by func_eu[2:0], with func_eu[8] (funct7 bit 5) as modifier: 000 ADD (SUB when bit set), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL (SRA when bit set), 110 OR, 111 AND.
REQ-022 All other funct7 bits SHALL be ignored; func_eu[8] SHALL be ignored for every op except 000 and 101.
REQ-023 Add/sub SHALL wrap modulo 2^XLEN with no carry output.
REQ-024 Shift amount SHALL be operand B[4:0].
REQ-025 SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-026 aluout SHALL be purely combinational, with zero cycles of latency.
REQ-027 ben SHALL be 0 unless opcode == 7'b1100011.
REQ-028 When opcode == 7'b1100011, ben SHALL follow func3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010/011: ben SHALL be 0.
REQ-029 ben SHALL compare src1 against src2 only, never ALU operands, and SHALL be combinational.
REQ-030 CSR file SHALL implement mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, each XLEN wide.
REQ-031 csr_rdata SHALL be the combinational read of the csr_addr register; unimplemented addresses SHALL read 0.
REQ-032 On a rising edge with csr_wen=1 and rst=0, the addressed register SHALL load aluout.
REQ-033 Writes to unimplemented addresses SHALL be ignored.
REQ-034 A write SHALL be visible on csr_rdata from the cycle after the edge.
REQ-035 During a write cycle, csr_rdata SHALL return the old value; there is no write-through bypass.

Reset
REQ-036 When rst=1 at a rising edge, mstatus SHALL become 32'h0000_1800 and mtvec, mepc, mcause SHALL become 0.
REQ-037 When rst and csr_wen are both high, reset SHALL win.
REQ-038 aluout and ben SHALL carry no state and SHALL be unaffected by reset.
REQ-039 After reset, csr_rdata SHALL reflect the reset values.

Structure
REQ-040 A shared package SHALL hold:
  - ALU funct3 codes, branch funct3 codes, and the OP_BRANCH opcode constant.
  - amux select encodings.
  - CSR addresses and the mstatus reset value.
REQ-041 The CSR register file SHALL be one sub-module, csr_file, clocked by clk and rst.
REQ-042 ALU and branch compare SHALL be combinational logic in execute_stage.

Verification
REQ-043 ALU SUB: amux1=00, amux2=00, func_eu=10'b0100000_000, src1=5, src2=7 -> aluout=32'hFFFF_FFFE.
REQ-044 ALU SRA: amux2=01, imm=32'h24, func_eu=10'b0100000_101, src1=32'h8000_0000 -> aluout=32'hF800_0000 (shift 4); with func_eu[8]=0 -> 32'h0800_0000.
REQ-045 JAL/AUIPC target: amux1=01, amux2=01, pc=32'h8000_0010, imm=32'hFFFF_FFF0, func_eu=0 -> aluout=32'h8000_0000.
REQ-046 Branch compare: opcode=1100011, src1=32'hFFFF_FFFF, src2=1:
  - func3=100 (BLT) -> ben=1; func3=110 (BLTU) -> ben=0.
  - opcode=0110011, same inputs -> ben=0.
REQ-047 CSR write/read-back:
  - Reset -> csr_addr=0x300 reads 32'h1800.
  - Write 0x305 with aluout=32'h8000_0100 -> same cycle reads old 0, next cycle reads 32'h8000_0100.
  - Write to 0x7C0, then read it -> 0.
REQ-048 Reset priority: rst=1 and csr_wen=1 to 0x341 with aluout=32'h1234 -> mepc reads 0 next cycle.
